music_speech_ram_arbiter: RTL and testbench

- Sequences the 128x8 music/speech SRAM and shares its single port between two requesters: the on-card 6809 CPU and the host CoCo bus.
- Converts the CPU's access into a req/ack handshake and produces a hold for the 6809.
- Provides a host-to-CPU mailbox interrupt on a designated SRAM address.
- Sits between cpu09, the host-bus decode and the SRAM instance inside the music/speech SOC.

---
 rtl/music_speech_pkg.sv | 23 ++
 rtl/music_speech_rr_arb.sv | 51 +++++
 rtl/music_speech_ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_music_speech_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_speech_pkg.sv
// Shared types and defaults for the music/speech SRAM arbiter.
// Contents:
//   state_t - access sequencer states (IDLE, ACCESS, DONE)
//   grant_t - which requester owns the current SRAM access
//   MS_ADDR_W, MS_DATA_W, MS_MBOX_ADDR - default geometry and mailbox byte
package music_speech_pkg;

    localparam int MS_ADDR_W    = 7;
    localparam int MS_DATA_W    = 8;
    localparam int MS_MBOX_ADDR = 'h7F;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_HOST
    } grant_t;

endpackage

// File: rtl/music_speech_rr_arb.sv
// Two-way grant selector for the music/speech SRAM port.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   cpu_req    - CPU side is requesting
//   host_req   - host side is requesting
//   grant_en   - the sequencer is taking the grant this cycle
//   grant      - combinational winner for the current requests
//   any_req    - at least one side is requesting
// With RR = 1 a tie goes to the side that did not win last time; with
// RR = 0 the host always wins a tie.
module music_speech_rr_arb
    import music_speech_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   cpu_req,
    input  logic   host_req,
    input  logic   grant_en,
    output grant_t grant,
    output logic   any_req
);

    grant_t last_grant;

    assign any_req = cpu_req | host_req;

    always_comb begin
        grant = GNT_CPU;
        if (cpu_req && host_req) begin
            if (RR) begin
                grant = (last_grant == GNT_HOST) ? GNT_CPU : GNT_HOST;
            end else begin
                grant = GNT_HOST;
            end
        end else if (host_req) begin
            grant = GNT_HOST;
        end
    end

    // Resetting to HOST makes the CPU the winner of the very first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GNT_HOST;
        end else if (grant_en) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/music_speech_ram_arbiter.sv
// Sequences the 128x8 music/speech SRAM and shares its single port between
// the on-card 6809 and the host CoCo bus. Each access runs IDLE -> ACCESS ->
// DONE -> IDLE and ends with a one-cycle ACK to the granted side.
// Ports:
//   CLKIN, RESET_N          - clock, asynchronous active-low reset
//   CPU_REQ/RW_N/ADDR/WDATA - CPU request (held until CPU_ACK)
//   CPU_RDATA, CPU_ACK      - read data (valid with ACK), completion pulse
//   CPU_HOLD                - stalls cpu09 while its request is outstanding
//   CPU_IRQ_N               - mailbox interrupt, active low
//   HOST_*                  - same handshake for the host bus
//   RAM_ADDR/R_N/ENA/DATA_I - SRAM address, read strobe, write enable, data
//   RAM_DATA_O              - SRAM read data, one cycle after the address
module music_speech_ram_arbiter
    import music_speech_pkg::*;
#(
    parameter int                ADDR_W    = MS_ADDR_W,
    parameter int                DATA_W    = MS_DATA_W,
    parameter bit                RR        = 1'b1,
    parameter logic [ADDR_W-1:0] MBOX_ADDR = ADDR_W'(MS_MBOX_ADDR)
) (
    input  logic              CLKIN,
    input  logic              RESET_N,
    input  logic              CPU_REQ,
    input  logic              CPU_RW_N,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    output logic              CPU_HOLD,
    output logic              CPU_IRQ_N,
    input  logic              HOST_REQ,
    input  logic              HOST_RW_N,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic [DATA_W-1:0] HOST_RDATA,
    output logic              HOST_ACK,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_R_N,
    output logic              RAM_ENA,
    output logic [DATA_W-1:0] RAM_DATA_I,
    input  logic [DATA_W-1:0] RAM_DATA_O
);

    state_t            state, state_nxt;
    grant_t            gnt_q, arb_gnt;
    logic              arb_any;
    logic              grant_take;
    logic              mbox_flag, mbox_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw_n;
    logic [DATA_W-1:0] sel_wdata;

    music_speech_rr_arb #(
        .RR(RR)
    ) u_arb (
        .clk     (CLKIN),
        .rst_n   (RESET_N),
        .cpu_req (CPU_REQ),
        .host_req(HOST_REQ),
        .grant_en(grant_take),
        .grant   (arb_gnt),
        .any_req (arb_any)
    );

    // Only the winner's fields are ever looked at, so garbage on the idle
    // side never reaches the SRAM.
    assign sel_addr  = (arb_gnt == GNT_HOST) ? HOST_ADDR  : CPU_ADDR;
    assign sel_rw_n  = (arb_gnt == GNT_HOST) ? HOST_RW_N  : CPU_RW_N;
    assign sel_wdata = (arb_gnt == GNT_HOST) ? HOST_WDATA : CPU_WDATA;

    assign CPU_HOLD = CPU_REQ & ~CPU_ACK;

    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The ACK cycle is already IDLE, so a requester that keeps REQ high
    // through its ACK gets a second access at the end of that cycle.
    always_comb begin
        state_nxt  = state;
        grant_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt  = ACCESS;
                    grant_take = 1'b1;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM_R_N and RAM_ADDR still describe the granted access during DONE,
    // so they double as the remembered rw/addr for the mailbox decode.
    always_comb begin
        mbox_nxt = mbox_flag;
        if (state == DONE && RAM_ADDR == MBOX_ADDR) begin
            if (gnt_q == GNT_HOST && !RAM_R_N) begin
                mbox_nxt = 1'b1;
            end else if (gnt_q == GNT_CPU && RAM_R_N) begin
                mbox_nxt = 1'b0;
            end
        end
    end

    // Datapath: latch the winner at grant, drop the write enable after the
    // single ACCESS cycle, and return data plus ACK out of DONE.
    always_ff @(posedge CLKIN or negedge RESET_N) begin
        if (!RESET_N) begin
            gnt_q      <= GNT_CPU;
            RAM_ADDR   <= '0;
            RAM_R_N    <= 1'b1;
            RAM_ENA    <= 1'b0;
            RAM_DATA_I <= '0;
            CPU_ACK    <= 1'b0;
            HOST_ACK   <= 1'b0;
            CPU_RDATA  <= '0;
            HOST_RDATA <= '0;
            mbox_flag  <= 1'b0;
            CPU_IRQ_N  <= 1'b1;
        end else begin
            CPU_ACK   <= 1'b0;
            HOST_ACK  <= 1'b0;
            mbox_flag <= mbox_nxt;
            CPU_IRQ_N <= ~mbox_nxt;
            case (state)
                IDLE: begin
                    if (grant_take) begin
                        gnt_q    <= arb_gnt;
                        RAM_ADDR <= sel_addr;
                        RAM_R_N  <= sel_rw_n;
                        RAM_ENA  <= ~sel_rw_n;
                        if (!sel_rw_n) begin
                            RAM_DATA_I <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    RAM_ENA <= 1'b0;
                end
                DONE: begin
                    if (gnt_q == GNT_CPU) begin
                        CPU_ACK <= 1'b1;
                        if (RAM_R_N) begin
                            CPU_RDATA <= RAM_DATA_O;
                        end
                    end else begin
                        HOST_ACK <= 1'b1;
                        if (RAM_R_N) begin
                            HOST_RDATA <= RAM_DATA_O;
                        end
                    end
                end
                default: begin
                    RAM_ENA <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_music_speech_ram_arbiter.sv
// Self-checking bench for music_speech_ram_arbiter. A round-robin instance
// carries almost all traffic; a fixed-priority instance shares the request
// fields and is exercised only while both sides hold their requests.
module tb_music_speech_ram_arbiter;

    localparam int SIDE_CPU  = 0;
    localparam int SIDE_HOST = 1;
    localparam logic [6:0] MBOX = 7'h7F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sram_clear = 1'b0;

    logic       cpu_req = 1'b0, cpu_rw_n, host_req = 1'b0, host_rw_n;
    logic [6:0] cpu_addr, host_addr;
    logic [7:0] cpu_wdata, host_wdata;
    logic [7:0] cpu_rdata, host_rdata;
    logic       cpu_ack, cpu_hold, cpu_irq_n, host_ack;
    logic [6:0] ram_addr;
    logic       ram_r_n, ram_ena;
    logic [7:0] ram_data_i, ram_data_o;

    logic       fp_cpu_req = 1'b0, fp_host_req = 1'b0;
    logic [7:0] fp_cpu_rdata, fp_host_rdata;
    logic       fp_cpu_ack, fp_cpu_hold, fp_cpu_irq_n, fp_host_ack;
    logic [6:0] fp_ram_addr;
    logic       fp_ram_r_n, fp_ram_ena;
    logic [7:0] fp_ram_data_i, fp_ram_data_o;

    logic [7:0] sram0 [128];
    logic [7:0] sram1 [128];

    // Reference state: memory contents, mailbox flag and who won last.
    logic [7:0] mem [128];
    bit         mbox;
    int         last_side;
    int         assert_count = 0;
    int         fail_count = 0;

    always #5 clk = ~clk;

    music_speech_ram_arbiter dut (
        .CLKIN(clk), .RESET_N(rst_n),
        .CPU_REQ(cpu_req), .CPU_RW_N(cpu_rw_n), .CPU_ADDR(cpu_addr),
        .CPU_WDATA(cpu_wdata), .CPU_RDATA(cpu_rdata), .CPU_ACK(cpu_ack),
        .CPU_HOLD(cpu_hold), .CPU_IRQ_N(cpu_irq_n),
        .HOST_REQ(host_req), .HOST_RW_N(host_rw_n), .HOST_ADDR(host_addr),
        .HOST_WDATA(host_wdata), .HOST_RDATA(host_rdata), .HOST_ACK(host_ack),
        .RAM_ADDR(ram_addr), .RAM_R_N(ram_r_n), .RAM_ENA(ram_ena),
        .RAM_DATA_I(ram_data_i), .RAM_DATA_O(ram_data_o)
    );

    music_speech_ram_arbiter #(.RR(1'b0)) dut_fp (
        .CLKIN(clk), .RESET_N(rst_n),
        .CPU_REQ(fp_cpu_req), .CPU_RW_N(cpu_rw_n), .CPU_ADDR(cpu_addr),
        .CPU_WDATA(cpu_wdata), .CPU_RDATA(fp_cpu_rdata), .CPU_ACK(fp_cpu_ack),
        .CPU_HOLD(fp_cpu_hold), .CPU_IRQ_N(fp_cpu_irq_n),
        .HOST_REQ(fp_host_req), .HOST_RW_N(host_rw_n), .HOST_ADDR(host_addr),
        .HOST_WDATA(host_wdata), .HOST_RDATA(fp_host_rdata), .HOST_ACK(fp_host_ack),
        .RAM_ADDR(fp_ram_addr), .RAM_R_N(fp_ram_r_n), .RAM_ENA(fp_ram_ena),
        .RAM_DATA_I(fp_ram_data_i), .RAM_DATA_O(fp_ram_data_o)
    );

    // Synchronous SRAMs: address registered on the edge, data out the
    // following cycle; cleared once at start-up so every read is defined.
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < 128; i++) begin
                sram0[i] <= 8'h00;
                sram1[i] <= 8'h00;
            end
        end else begin
            if (ram_ena) sram0[ram_addr] <= ram_data_i;
            if (fp_ram_ena) sram1[fp_ram_addr] <= fp_ram_data_i;
        end
        ram_data_o    <= sram0[ram_addr];
        fp_ram_data_o <= sram1[fp_ram_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply the effect of one completed access to the reference state and
    // compare the returned data and interrupt line.
    task automatic model_access(input string tag, input int side, input bit rw_n,
                                input logic [6:0] a, input logic [7:0] d);
        if (rw_n) begin
            if (side == SIDE_CPU) begin
                check_output({tag, " cpu_rdata"}, cpu_rdata, mem[a]);
                if (a == MBOX) mbox = 1'b0;
            end else begin
                check_output({tag, " host_rdata"}, host_rdata, mem[a]);
            end
        end else begin
            mem[a] = d;
            if (side == SIDE_HOST && a == MBOX) mbox = 1'b1;
        end
        last_side = side;
        check_output({tag, " cpu_irq_n"}, cpu_irq_n, !mbox);
    endtask

    // One request per enabled side, raised together; each side drops its
    // REQ in its own ACK cycle. ACK timing is predicted from the rules:
    // the first winner acks 3 cycles after the request, the loser 3 later.
    task automatic apply_stimulus(input string tag,
                                  input bit c_en, input bit c_rw, input logic [6:0] c_a, input logic [7:0] c_d,
                                  input bit h_en, input bit h_rw, input logic [6:0] h_a, input logic [7:0] h_d);
        int first_side, c_cyc, h_cyc, last_cyc, ena_cycles, writes_expected;
        logic [6:0] ena_addr, wr_addr;
        if (c_en && h_en) first_side = (last_side == SIDE_HOST) ? SIDE_CPU : SIDE_HOST;
        else first_side = c_en ? SIDE_CPU : SIDE_HOST;
        c_cyc = !c_en ? 0 : ((first_side == SIDE_CPU) ? 3 : 6);
        h_cyc = !h_en ? 0 : ((first_side == SIDE_HOST) ? 3 : 6);
        last_cyc = (c_cyc > h_cyc) ? c_cyc : h_cyc;
        writes_expected = int'(c_en && !c_rw) + int'(h_en && !h_rw);
        wr_addr = (c_en && !c_rw) ? c_a : h_a;
        ena_cycles = 0;
        ena_addr = '0;
        @(negedge clk);
        cpu_req   = c_en;
        cpu_rw_n  = c_en ? c_rw : 1'bx;
        cpu_addr  = c_en ? c_a : 7'bx;
        cpu_wdata = c_en ? c_d : 8'bx;
        host_req   = h_en;
        host_rw_n  = h_en ? h_rw : 1'bx;
        host_addr  = h_en ? h_a : 7'bx;
        host_wdata = h_en ? h_d : 8'bx;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            @(negedge clk);
            if (ram_ena === 1'b1) begin
                ena_cycles++;
                ena_addr = ram_addr;
            end
            check_output({tag, " cpu_ack"}, cpu_ack, cyc == c_cyc);
            check_output({tag, " host_ack"}, host_ack, cyc == h_cyc);
            if (c_en && cyc <= c_cyc) check_output({tag, " cpu_hold"}, cpu_hold, cyc != c_cyc);
            if (cyc == c_cyc) begin
                model_access(tag, SIDE_CPU, c_rw, c_a, c_d);
                cpu_req = 1'b0;
                cpu_addr = 7'bx;
                cpu_wdata = 8'bx;
            end
            if (cyc == h_cyc) begin
                model_access(tag, SIDE_HOST, h_rw, h_a, h_d);
                host_req = 1'b0;
                host_addr = 7'bx;
                host_wdata = 8'bx;
            end
        end
        check_output({tag, " ram_ena cycles"}, ena_cycles, writes_expected);
        if (writes_expected == 1) check_output({tag, " ram_ena addr"}, ena_addr, wr_addr);
    endtask

    // Both sides hold read requests continuously for n accesses: the RR
    // instance must alternate, the fixed-priority one must serve only host.
    task automatic hold_both(input int n);
        int nxt;
        nxt = (last_side == SIDE_HOST) ? SIDE_CPU : SIDE_HOST;
        @(negedge clk);
        cpu_req = 1'b1;  cpu_rw_n = 1'b1;  cpu_addr = 7'h10;
        host_req = 1'b1; host_rw_n = 1'b1; host_addr = 7'h11;
        fp_cpu_req = 1'b1; fp_host_req = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                check_output("hold_both cpu_ack", cpu_ack, c == 3 && nxt == SIDE_CPU);
                check_output("hold_both host_ack", host_ack, c == 3 && nxt == SIDE_HOST);
                check_output("fixed_prio cpu_ack", fp_cpu_ack, 0);
                check_output("fixed_prio host_ack", fp_host_ack, c == 3);
            end
            model_access("hold_both", nxt, 1'b1, (nxt == SIDE_CPU) ? 7'h10 : 7'h11, 8'h00);
            nxt = (nxt == SIDE_CPU) ? SIDE_HOST : SIDE_CPU;
        end
        cpu_req = 1'b0; host_req = 1'b0;
        fp_cpu_req = 1'b0; fp_host_req = 1'b0;
        cpu_addr = 7'bx; host_addr = 7'bx;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mbox = 1'b0;
        last_side = SIDE_HOST;
        cpu_rw_n = 1'bx; cpu_addr = 7'bx; cpu_wdata = 8'bx;
        host_rw_n = 1'bx; host_addr = 7'bx; host_wdata = 8'bx;

        $display("[TB] reset and SRAM clear");
        sram_clear = 1'b1;
        repeat (3) @(negedge clk);
        sram_clear = 1'b0;
        check_output("reset ram_ena", ram_ena, 0);
        check_output("reset ram_r_n", ram_r_n, 1);
        check_output("reset ram_addr", ram_addr, 0);
        check_output("reset ram_data_i", ram_data_i, 0);
        check_output("reset cpu_ack", cpu_ack, 0);
        check_output("reset host_ack", host_ack, 0);
        check_output("reset cpu_rdata", cpu_rdata, 0);
        check_output("reset host_rdata", host_rdata, 0);
        check_output("reset cpu_irq_n", cpu_irq_n, 1);
        rst_n = 1'b1;

        $display("[TB] directed single accesses");
        apply_stimulus("cpu_wr_10", 1, 0, 7'h10, 8'hA5, 0, 1, 7'h00, 8'h00);
        apply_stimulus("host_rd_10", 0, 1, 7'h00, 8'h00, 1, 1, 7'h10, 8'h00);
        apply_stimulus("setup_20_21", 1, 0, 7'h20, 8'h11, 1, 0, 7'h21, 8'h22);

        $display("[TB] request fields changed after grant");
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 7'h20;
        @(negedge clk);
        cpu_addr = 7'h21;
        check_output("late_addr ram_addr", ram_addr, 7'h20);
        @(negedge clk);
        @(negedge clk);
        check_output("late_addr cpu_ack", cpu_ack, 1);
        check_output("late_addr cpu_rdata", cpu_rdata, mem[7'h20]);
        last_side = SIDE_CPU;
        cpu_req = 1'b0; cpu_addr = 7'bx;

        $display("[TB] both requests held");
        hold_both(6);

        $display("[TB] mailbox");
        apply_stimulus("mbox_host_wr", 0, 1, 7'h00, 8'h00, 1, 0, MBOX, 8'h3C);
        apply_stimulus("mbox_host_rd", 0, 1, 7'h00, 8'h00, 1, 1, MBOX, 8'h00);
        apply_stimulus("mbox_cpu_rd", 1, 1, MBOX, 8'h00, 0, 1, 7'h00, 8'h00);
        apply_stimulus("mbox_host_wr2", 0, 1, 7'h00, 8'h00, 1, 0, MBOX, 8'h3C);
        apply_stimulus("mbox_cpu_wr", 1, 0, MBOX, 8'h5A, 0, 1, 7'h00, 8'h00);
        apply_stimulus("mbox_cpu_rd2", 1, 1, MBOX, 8'h00, 0, 1, 7'h00, 8'h00);
        apply_stimulus("mbox_host_wr3", 0, 1, 7'h00, 8'h00, 1, 0, MBOX, 8'h77);

        $display("[TB] reset during ACCESS");
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 7'h10;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort ram_ena", ram_ena, 0);
        check_output("abort ram_r_n", ram_r_n, 1);
        check_output("abort ram_addr", ram_addr, 0);
        check_output("abort ram_data_i", ram_data_i, 0);
        check_output("abort cpu_rdata", cpu_rdata, 0);
        check_output("abort host_rdata", host_rdata, 0);
        check_output("abort cpu_irq_n", cpu_irq_n, 1);
        cpu_req = 1'b0; cpu_addr = 7'bx;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("abort cpu_ack", cpu_ack, 0);
            check_output("abort host_ack", host_ack, 0);
        end
        rst_n = 1'b1;
        mbox = 1'b0;
        last_side = SIDE_HOST;
        apply_stimulus("after_reset", 1, 1, 7'h10, 8'h00, 0, 1, 7'h00, 8'h00);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            int mode;
            bit c_rw, h_rw;
            logic [6:0] c_a, h_a;
            logic [7:0] c_d, h_d;
            mode = int'($urandom_range(0, 2));
            c_rw = 1'($urandom_range(0, 1));
            h_rw = 1'($urandom_range(0, 1));
            c_a = ($urandom_range(0, 7) == 0) ? MBOX : 7'($urandom_range(0, 127));
            h_a = ($urandom_range(0, 7) == 0) ? MBOX : 7'($urandom_range(0, 127));
            c_d = 8'($urandom);
            h_d = 8'($urandom);
            apply_stimulus("random", mode != 1, c_rw, c_a, c_d, mode != 0, h_rw, h_a, h_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
